// File: rtl/radio_uplink_tx.sv
// Uplink word serialiser for the four-wire radio interface (RPULSE, RD1, RD0, RCHECK).
// Each 14-bit word goes out as one sync frame (RD1=RD0=RCHECK=1) followed by
// seven dibit frames, MSB pair first. Every line output is registered, so all
// line values are computed from the next-state values.
//
// state   | meaning
// --------+-------------------------------------------------------------
// IDLE    | lines low, word_ready high, waiting for word_valid
// S_SETUP | sync pattern on RD1/RD0/RCHECK, RPULSE low
// S_PULSE | sync pattern held, RPULSE high for SYNC_W clocks
// S_GAP   | sync pattern held, RPULSE low
// D_SETUP | current dibit and its parity on the lines, RPULSE low
// D_PULSE | dibit held, RPULSE high for PULSE_W clocks
// D_GAP   | dibit held, RPULSE low; shift to next dibit or finish
module radio_uplink_tx #(
  parameter int SETUP   = 2,
  parameter int PULSE_W = 4,
  parameter int GAP     = 4,
  parameter int SYNC_W  = 8
) (
  input  logic        clk,
  input  logic        rstb,
  input  logic [13:0] word_in,
  input  logic        err_inject,
  input  logic        word_valid,
  output logic        word_ready,
  output logic        busy,
  output logic        done,
  output logic        RPULSE,
  output logic        RD1,
  output logic        RD0,
  output logic        RCHECK
);

  typedef enum logic [2:0] {
    IDLE, S_SETUP, S_PULSE, S_GAP, D_SETUP, D_PULSE, D_GAP
  } state_t;

  localparam int TW = 8;
  // Down-counter load values: a state lasting L clocks loads L-1 and exits at zero.
  localparam logic [TW-1:0] SETUP_LD = TW'(SETUP - 1);
  localparam logic [TW-1:0] PULSE_LD = TW'(PULSE_W - 1);
  localparam logic [TW-1:0] GAP_LD   = TW'(GAP - 1);
  localparam logic [TW-1:0] SYNC_LD  = TW'(SYNC_W - 1);
  localparam logic [2:0]    LAST_IDX = 3'd6;

  state_t        state, state_nx;
  logic [TW-1:0] tcnt, tcnt_nx;
  logic [2:0]    idx, idx_nx;
  logic [13:0]   shreg, shreg_nx;
  logic          err, err_nx;
  logic          pulse_nx, rd1_nx, rd0_nx, rchk_nx, busy_nx, done_nx;

  assign word_ready = (state == IDLE);

  // State, counters, payload and registered line outputs.
  always_ff @(posedge clk) begin
    if (!rstb) begin
      state  <= IDLE;
      tcnt   <= '0;
      idx    <= '0;
      shreg  <= '0;
      err    <= 1'b0;
      RPULSE <= 1'b0;
      RD1    <= 1'b0;
      RD0    <= 1'b0;
      RCHECK <= 1'b0;
      busy   <= 1'b0;
      done   <= 1'b0;
    end else begin
      state  <= state_nx;
      tcnt   <= tcnt_nx;
      idx    <= idx_nx;
      shreg  <= shreg_nx;
      err    <= err_nx;
      RPULSE <= pulse_nx;
      RD1    <= rd1_nx;
      RD0    <= rd0_nx;
      RCHECK <= rchk_nx;
      busy   <= busy_nx;
      done   <= done_nx;
    end
  end

  // Next-state logic: timed states advance when the down-counter reaches zero.
  always_comb begin
    state_nx = state;
    tcnt_nx  = (tcnt != '0) ? tcnt - TW'(1) : tcnt;
    idx_nx   = idx;
    shreg_nx = shreg;
    err_nx   = err;
    case (state)
      IDLE: begin
        if (word_valid) begin
          state_nx = S_SETUP;
          tcnt_nx  = SETUP_LD;
          shreg_nx = word_in;
          err_nx   = err_inject;
          idx_nx   = '0;
        end
      end
      S_SETUP: if (tcnt == '0) begin state_nx = S_PULSE; tcnt_nx = SYNC_LD;  end
      S_PULSE: if (tcnt == '0) begin state_nx = S_GAP;   tcnt_nx = GAP_LD;   end
      S_GAP:   if (tcnt == '0) begin state_nx = D_SETUP; tcnt_nx = SETUP_LD; end
      D_SETUP: if (tcnt == '0) begin state_nx = D_PULSE; tcnt_nx = PULSE_LD; end
      D_PULSE: if (tcnt == '0) begin state_nx = D_GAP;   tcnt_nx = GAP_LD;   end
      D_GAP: begin
        if (tcnt == '0) begin
          if (idx == LAST_IDX) begin
            state_nx = IDLE;
          end else begin
            state_nx = D_SETUP;
            tcnt_nx  = SETUP_LD;
            shreg_nx = {shreg[11:0], 2'b00};
            idx_nx   = idx + 3'd1;
          end
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // Line values for the coming cycle, derived from the next state so they register in step with it.
  always_comb begin
    pulse_nx = 1'b0;
    rd1_nx   = 1'b0;
    rd0_nx   = 1'b0;
    rchk_nx  = 1'b0;
    case (state_nx)
      S_SETUP, S_PULSE, S_GAP: begin
        rd1_nx  = 1'b1;
        rd0_nx  = 1'b1;
        rchk_nx = 1'b1;
      end
      D_SETUP, D_PULSE, D_GAP: begin
        rd1_nx  = shreg_nx[13];
        rd0_nx  = shreg_nx[12];
        rchk_nx = shreg_nx[13] ^ shreg_nx[12] ^ (err_nx && (idx_nx == LAST_IDX));
      end
      default: ;
    endcase
    pulse_nx = (state_nx == S_PULSE) || (state_nx == D_PULSE);
    busy_nx  = (state_nx != IDLE);
    // Final GAP cycle of the last dibit.
    done_nx  = (state_nx == D_GAP) && (tcnt_nx == '0) && (idx_nx == LAST_IDX);
  end

endmodule

// File: tb/tb_radio_uplink_tx.sv
// Directed bench for radio_uplink_tx with a behavioural model of the radio receiver.
module tb_radio_uplink_tx;

  logic        clk = 1'b0;
  logic        rstb;
  logic [13:0] word_in;
  logic        err_inject;
  logic        word_valid;
  logic        f_valid;
  logic        word_ready, busy, done, RPULSE, RD1, RD0, RCHECK;
  logic        f_ready, f_busy, f_done, f_pulse, f_rd1, f_rd0, f_rchk;

  int tests  = 0;
  int failed = 0;
  int cyc    = 0;

  radio_uplink_tx u_dut (
    .clk(clk), .rstb(rstb), .word_in(word_in), .err_inject(err_inject),
    .word_valid(word_valid), .word_ready(word_ready), .busy(busy), .done(done),
    .RPULSE(RPULSE), .RD1(RD1), .RD0(RD0), .RCHECK(RCHECK)
  );

  radio_uplink_tx #(.SETUP(1), .PULSE_W(1), .GAP(1), .SYNC_W(2)) u_fast (
    .clk(clk), .rstb(rstb), .word_in(word_in), .err_inject(err_inject),
    .word_valid(f_valid), .word_ready(f_ready), .busy(f_busy), .done(f_done),
    .RPULSE(f_pulse), .RD1(f_rd1), .RD0(f_rd0), .RCHECK(f_rchk)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Receiver model and event recorder for the default instance.
  int          acc_cnt = 0, acc_cyc = 0, done_cnt = 0, done_cyc = 0;
  logic [3:0]  acc_lines = '0;
  logic [13:0] rx_word = '0, done_word = '0;
  int          rx_cnt = 0, run = 0, sync_len = 0, dib_len = 0;
  bit          rx_par_ok = 0, done_int = 0, prev_pulse = 0;
  logic [2:0]  fr [7];
  logic [2:0]  last_frame = '0;

  always @(negedge clk) begin
    if (rstb === 1'b1 && word_valid === 1'b1 && word_ready === 1'b1) begin
      acc_cnt++;
      acc_cyc   = cyc;
      acc_lines = {RPULSE, RD1, RD0, RCHECK};
    end
    if (RPULSE === 1'b1 && !prev_pulse) begin
      last_frame = {RD1, RD0, RCHECK};
      if (last_frame == 3'b111) begin
        rx_word = '0; rx_cnt = 0; rx_par_ok = 1;
      end else begin
        if (rx_cnt < 7) fr[rx_cnt] = last_frame;
        rx_word = {rx_word[11:0], RD1, RD0};
        rx_cnt++;
        if (RCHECK !== (RD1 ^ RD0)) rx_par_ok = 0;
      end
    end
    if (RPULSE === 1'b1) run++;
    else if (prev_pulse) begin
      if ({RD1, RD0, RCHECK} == 3'b111) sync_len = run; else dib_len = run;
      run = 0;
    end
    prev_pulse = (RPULSE === 1'b1);
    if (done === 1'b1) begin
      done_cnt++;
      done_cyc  = cyc;
      done_word = rx_word;
      done_int  = (rx_cnt == 7) && rx_par_ok;
    end
  end

  // Receiver model for the short-timing instance.
  int          f_acc_cnt = 0, f_acc_cyc = 0, f_done_cnt = 0, f_done_cyc = 0, f_rx_cnt = 0;
  logic [13:0] f_rx_word = '0, f_done_word = '0;
  bit          f_par_ok = 0, f_done_int = 0, f_prev = 0;

  always @(negedge clk) begin
    if (rstb === 1'b1 && f_valid === 1'b1 && f_ready === 1'b1) begin
      f_acc_cnt++;
      f_acc_cyc = cyc;
    end
    if (f_pulse === 1'b1 && !f_prev) begin
      if ({f_rd1, f_rd0, f_rchk} == 3'b111) begin
        f_rx_word = '0; f_rx_cnt = 0; f_par_ok = 1;
      end else begin
        f_rx_word = {f_rx_word[11:0], f_rd1, f_rd0};
        f_rx_cnt++;
        if (f_rchk !== (f_rd1 ^ f_rd0)) f_par_ok = 0;
      end
    end
    f_prev = (f_pulse === 1'b1);
    if (f_done === 1'b1) begin
      f_done_cnt++;
      f_done_cyc  = cyc;
      f_done_word = f_rx_word;
      f_done_int  = (f_rx_cnt == 7) && f_par_ok;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_word(input logic [13:0] w, input logic e, input bit keep, output bit ok);
    int prev;
    prev = acc_cnt;
    word_in = w; err_inject = e; word_valid = 1'b1; ok = 0;
    for (int i = 0; i < 300; i++) begin
      tick();
      if (acc_cnt != prev) begin ok = 1; break; end
    end
    if (!keep) word_valid = 1'b0;
    if (!ok) begin
      tests++; failed++;
      $display("FAIL accept_timeout: acc_cnt=%0d required>%0d", acc_cnt, prev);
    end
  endtask

  task automatic wait_done(output bit ok);
    int prev;
    prev = done_cnt; ok = 0;
    for (int i = 0; i < 300; i++) begin
      tick();
      if (done_cnt != prev) begin ok = 1; break; end
    end
    if (!ok) begin
      tests++; failed++;
      $display("FAIL done_timeout: done_cnt=%0d required>%0d", done_cnt, prev);
    end
  endtask

  task automatic test_reset();
    rstb = 1'b0; word_valid = 1'b1; f_valid = 1'b0; word_in = 14'h1234; err_inject = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      tests++;
      if ({RPULSE, RD1, RD0, RCHECK, busy, done} !== 6'b0) begin
        failed++;
        $display("FAIL reset_outputs[%0d]: got %b required 000000", i, {RPULSE, RD1, RD0, RCHECK, busy, done});
      end
    end
    rstb = 1'b1; word_valid = 1'b0;
    tick();
    tests++;
    if (word_ready !== 1'b1) begin failed++; $display("FAIL reset_ready: got %b required 1", word_ready); end
    tests++;
    if (busy !== 1'b0) begin failed++; $display("FAIL reset_no_accept: busy=%b required 0", busy); end
  endtask

  task automatic test_single_word();
    logic [2:0] exp_fr [7];
    bit ok;
    exp_fr = '{3'b101, 3'b101, 3'b101, 3'b011, 3'b011, 3'b110, 3'b000};
    start_word(14'h2A5C, 1'b0, 0, ok);
    word_in = 14'h0000; err_inject = 1'b1;
    wait_done(ok);
    tests++;
    if (done_cyc - acc_cyc !== 84) begin failed++; $display("FAIL single_len: got %0d required 84", done_cyc - acc_cyc); end
    tests++;
    if (sync_len !== 8) begin failed++; $display("FAIL single_sync_len: got %0d required 8", sync_len); end
    tests++;
    if (dib_len !== 4) begin failed++; $display("FAIL single_pulse_len: got %0d required 4", dib_len); end
    for (int i = 0; i < 7; i++) begin
      tests++;
      if (fr[i] !== exp_fr[i]) begin
        failed++;
        $display("FAIL single_frame[%0d]: got %b required %b", i, fr[i], exp_fr[i]);
      end
    end
    tests++;
    if (done_word !== 14'h2A5C) begin failed++; $display("FAIL single_word: got %h required 2a5c", done_word); end
    tests++;
    if (done_int !== 1'b1) begin failed++; $display("FAIL single_irq: got %b required 1", done_int); end
    tests++;
    if ({word_ready, busy, done, RPULSE, RD1, RD0, RCHECK} !== 7'b1000000) begin
      failed++;
      $display("FAIL single_idle: got %b required 1000000", {word_ready, busy, done, RPULSE, RD1, RD0, RCHECK});
    end
  endtask

  task automatic test_err_inject();
    bit ok;
    start_word(14'h3FFF, 1'b1, 0, ok);
    wait_done(ok);
    tests++;
    if (last_frame !== 3'b111) begin failed++; $display("FAIL err_last_frame: got %b required 111", last_frame); end
    tests++;
    if (done_int !== 1'b0) begin failed++; $display("FAIL err_irq: got %b required 0", done_int); end
    start_word(14'h3FFF, 1'b0, 0, ok);
    wait_done(ok);
    tests++;
    if (last_frame !== 3'b110) begin failed++; $display("FAIL clean_last_frame: got %b required 110", last_frame); end
    tests++;
    if (done_int !== 1'b1) begin failed++; $display("FAIL clean_irq: got %b required 1", done_int); end
    tests++;
    if (done_word !== 14'h3FFF) begin failed++; $display("FAIL clean_word: got %h required 3fff", done_word); end
  endtask

  task automatic test_back_to_back();
    bit ok;
    start_word(14'h0001, 1'b0, 1, ok);
    word_in = 14'h3FFE;
    wait_done(ok);
    tests++;
    if (done_word !== 14'h0001) begin failed++; $display("FAIL b2b_word0: got %h required 0001", done_word); end
    tests++;
    if (done_int !== 1'b1) begin failed++; $display("FAIL b2b_irq0: got %b required 1", done_int); end
    start_word(14'h3FFE, 1'b0, 0, ok);
    tests++;
    if (acc_cyc - done_cyc !== 1) begin failed++; $display("FAIL b2b_gap: got %0d required 1", acc_cyc - done_cyc); end
    tests++;
    if (acc_lines !== 4'b0000) begin failed++; $display("FAIL b2b_idle_lines: got %b required 0000", acc_lines); end
    wait_done(ok);
    tests++;
    if (done_word !== 14'h3FFE) begin failed++; $display("FAIL b2b_word1: got %h required 3ffe", done_word); end
    tests++;
    if (done_cyc - acc_cyc !== 84) begin failed++; $display("FAIL b2b_len1: got %0d required 84", done_cyc - acc_cyc); end
  endtask

  task automatic test_mid_reset();
    bit ok;
    int d0;
    ok = 0;
    start_word(14'h155A, 1'b0, 0, ok);
    for (int i = 0; i < 200; i++) begin
      if (rx_cnt == 4 && RPULSE === 1'b1) begin ok = 1; break; end
      tick();
    end
    if (!ok) begin tests++; failed++; $display("FAIL midrst_timeout: rx_cnt=%0d required 4", rx_cnt); end
    d0 = done_cnt;
    rstb = 1'b0;
    tick();
    tests++;
    if ({RPULSE, RD1, RD0, RCHECK, busy, done} !== 6'b0) begin
      failed++;
      $display("FAIL midrst_outputs: got %b required 000000", {RPULSE, RD1, RD0, RCHECK, busy, done});
    end
    rstb = 1'b1;
    repeat (100) tick();
    tests++;
    if (done_cnt !== d0) begin failed++; $display("FAIL midrst_no_done: got %0d required %0d", done_cnt, d0); end
    start_word(14'h1C3B, 1'b0, 0, ok);
    wait_done(ok);
    tests++;
    if (done_cyc - acc_cyc !== 84) begin failed++; $display("FAIL midrst_len: got %0d required 84", done_cyc - acc_cyc); end
    tests++;
    if (done_word !== 14'h1C3B) begin failed++; $display("FAIL midrst_word: got %h required 1c3b", done_word); end
    tests++;
    if (done_int !== 1'b1) begin failed++; $display("FAIL midrst_irq: got %b required 1", done_int); end
  endtask

  task automatic test_param_sweep();
    int pa, pd;
    bit ok;
    pa = f_acc_cnt; pd = f_done_cnt; ok = 0;
    word_in = 14'h0F96; err_inject = 1'b0; f_valid = 1'b1;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (f_acc_cnt != pa) begin ok = 1; break; end
    end
    f_valid = 1'b0;
    if (!ok) begin tests++; failed++; $display("FAIL sweep_accept_timeout: acc=%0d required>%0d", f_acc_cnt, pa); end
    ok = 0;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (f_done_cnt != pd) begin ok = 1; break; end
    end
    if (!ok) begin tests++; failed++; $display("FAIL sweep_done_timeout: done=%0d required>%0d", f_done_cnt, pd); end
    tests++;
    if (f_done_cyc - f_acc_cyc !== 25) begin failed++; $display("FAIL sweep_len: got %0d required 25", f_done_cyc - f_acc_cyc); end
    tests++;
    if (f_done_word !== 14'h0F96) begin failed++; $display("FAIL sweep_word: got %h required 0f96", f_done_word); end
    tests++;
    if (f_done_int !== 1'b1) begin failed++; $display("FAIL sweep_irq: got %b required 1", f_done_int); end
  endtask

  initial begin
    test_reset();
    test_single_word();
    test_err_inject();
    test_back_to_back();
    test_mid_reset();
    test_param_sweep();
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
